// File: rtl/ob_cn_table.sv
// Conditional-order table: holds stop orders until a trade execution
// triggers them, ages them with a per-entry TTL, and issues matured
// commands downstream in round-robin order.

package bcd_pkg;
  // Four packed BCD digits; ordering matches plain unsigned compare.
  typedef logic [15:0] price_t;
endpackage

package ob_pkg;
  typedef logic [7:0] uid_t;

  typedef enum logic [3:0] {
    OP_NOP             = 4'd0,
    OP_BUY_LIMIT       = 4'd1,
    OP_SELL_LIMIT      = 4'd2,
    OP_BUY_MARKET      = 4'd3,
    OP_SELL_MARKET     = 4'd4,
    OP_BUY_STOP_LOSS   = 4'd5,
    OP_SELL_STOP_LOSS  = 4'd6,
    OP_BUY_STOP_LIMIT  = 4'd7,
    OP_SELL_STOP_LIMIT = 4'd8
  } opcode_t;

  typedef struct packed {
    opcode_t          opcode;
    uid_t             uid;
    bcd_pkg::price_t  price1;
    bcd_pkg::price_t  price2;
    logic [15:0]      qty;
  } cmd_t;

  typedef enum logic [1:0] {
    ENT_IDLE    = 2'd0,
    ENT_ACTIVE  = 2'd1,
    ENT_MATURED = 2'd2,
    ENT_EXPIRED = 2'd3
  } ent_state_t;
endpackage

module ob_cn_table #(
  parameter int N     = 4,
  parameter int TTL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  input  ob_pkg::cmd_t           in_cmd,
  input  logic [TTL_W-1:0]       in_ttl,
  output logic                   in_rdy,
  input  logic                   cntrl_evt_texe_r,
  input  bcd_pkg::price_t        cntrl_evt_texe_ask_r,
  input  bcd_pkg::price_t        cntrl_evt_texe_bid_r,
  input  logic                   cancel,
  input  ob_pkg::uid_t           cancel_uid,
  output logic                   cancel_hit,
  output logic                   out_vld,
  output ob_pkg::cmd_t           out_cmd,
  input  logic                   out_rdy,
  output logic                   exp_vld,
  output ob_pkg::uid_t           exp_uid,
  output logic [$clog2(N+1)-1:0] count_r,
  output logic                   empty_r,
  output logic                   full_r
);
  import ob_pkg::*;

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);

  ent_state_t       r_state [N];
  cmd_t             r_cmd   [N];
  logic [TTL_W-1:0] r_ttl   [N];
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_lock_idx;
  logic             r_lock_vld;
  logic             r_bubble;
  logic             r_exp_vld;
  uid_t             r_exp_uid;
  logic [CW-1:0]    r_count;

  ent_state_t       w_state_nxt [N];
  cmd_t             w_cmd_nxt   [N];
  logic [TTL_W-1:0] w_ttl_nxt   [N];
  logic [CW-1:0]    w_cnt_nxt;
  logic [N-1:0]     w_mature;
  logic [N-1:0]     w_cxl_match;
  logic             w_any_idle, w_any_exp, w_rr_found, w_lock_ok;
  logic [IW-1:0]    w_alloc_idx, w_exp_idx, w_rr_idx, w_rr_cand, w_pres_idx;
  logic             w_pres_vld, w_issue, w_pres_cancel;
  logic             w_alloc_fire, w_alloc_drop, w_alloc_do, w_in_stop;

  // Lowest-index free slot for allocation and lowest-index expired slot to report.
  always_comb begin
    w_any_idle  = 1'b0;
    w_alloc_idx = '0;
    w_any_exp   = 1'b0;
    w_exp_idx   = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (r_state[i] == ENT_IDLE) begin
        w_any_idle  = 1'b1;
        w_alloc_idx = IW'(i);
      end
      if (r_state[i] == ENT_EXPIRED) begin
        w_any_exp = 1'b1;
        w_exp_idx = IW'(i);
      end
    end
  end

  // Round-robin search among matured entries, starting just after the last issued slot.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_cand  = '0;
    for (int k = N; k >= 1; k--) begin
      w_rr_cand = IW'((int'(r_rr_ptr) + k) % N);
      if (r_state[w_rr_cand] == ENT_MATURED) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_rr_cand;
      end
    end
  end

  // Presented entry stays locked while stalled; a cancelled presentation leaves a one-cycle gap.
  always_comb begin
    w_lock_ok     = r_lock_vld && (r_state[r_lock_idx] == ENT_MATURED);
    w_pres_idx    = w_lock_ok ? r_lock_idx : w_rr_idx;
    w_pres_vld    = (w_lock_ok || w_rr_found) && !r_bubble;
    w_issue       = w_pres_vld && out_rdy;
    w_pres_cancel = cancel && w_pres_vld && !out_rdy &&
                    (r_cmd[w_pres_idx].uid == cancel_uid);
    w_alloc_fire  = in_vld && w_any_idle;
    w_alloc_drop  = w_alloc_fire && cancel && (in_cmd.uid == cancel_uid);
    w_alloc_do    = w_alloc_fire && !w_alloc_drop;
    w_in_stop     = (in_cmd.opcode == OP_BUY_STOP_LOSS)  || (in_cmd.opcode == OP_SELL_STOP_LOSS) ||
                    (in_cmd.opcode == OP_BUY_STOP_LIMIT) || (in_cmd.opcode == OP_SELL_STOP_LIMIT);
  end

  // Per-entry trigger test against the trade prices and cancel matching (an issuing entry is immune).
  always_comb begin
    w_mature    = '0;
    w_cxl_match = '0;
    for (int i = 0; i < N; i++) begin
      if ((r_cmd[i].opcode == OP_BUY_STOP_LOSS) || (r_cmd[i].opcode == OP_BUY_STOP_LIMIT))
        w_mature[i] = (r_cmd[i].price1 >= cntrl_evt_texe_ask_r);
      else if ((r_cmd[i].opcode == OP_SELL_STOP_LOSS) || (r_cmd[i].opcode == OP_SELL_STOP_LIMIT))
        w_mature[i] = (r_cmd[i].price1 <= cntrl_evt_texe_bid_r);
      w_cxl_match[i] = cancel && (r_state[i] != ENT_IDLE) &&
                       (r_cmd[i].uid == cancel_uid) &&
                       !(w_issue && (w_pres_idx == IW'(i)));
    end
  end

  // Entry next-state: allocate, evaluate on trade events, release on issue/expiry, clear on cancel.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cmd_nxt[i]   = r_cmd[i];
      w_ttl_nxt[i]   = r_ttl[i];
      case (r_state[i])
        ENT_IDLE: begin
          if (w_alloc_do && (w_alloc_idx == IW'(i))) begin
            w_state_nxt[i] = w_in_stop ? ENT_ACTIVE : ENT_MATURED;
            w_cmd_nxt[i]   = in_cmd;
            w_ttl_nxt[i]   = in_ttl;
          end
        end
        ENT_ACTIVE: begin
          if (cntrl_evt_texe_r) begin
            if (w_mature[i]) begin
              w_state_nxt[i] = ENT_MATURED;
              case (r_cmd[i].opcode)
                OP_BUY_STOP_LOSS:   w_cmd_nxt[i].opcode = OP_BUY_MARKET;
                OP_SELL_STOP_LOSS:  w_cmd_nxt[i].opcode = OP_SELL_MARKET;
                OP_BUY_STOP_LIMIT:  w_cmd_nxt[i].opcode = OP_BUY_LIMIT;
                OP_SELL_STOP_LIMIT: w_cmd_nxt[i].opcode = OP_SELL_LIMIT;
                default:            w_cmd_nxt[i].opcode = r_cmd[i].opcode;
              endcase
            end else if (r_ttl[i] == TTL_W'(1)) begin
              w_state_nxt[i] = ENT_EXPIRED;
            end else if (r_ttl[i] > TTL_W'(1)) begin
              w_ttl_nxt[i] = r_ttl[i] - TTL_W'(1);
            end
          end
        end
        ENT_MATURED: begin
          if (w_issue && (w_pres_idx == IW'(i)))
            w_state_nxt[i] = ENT_IDLE;
        end
        ENT_EXPIRED: begin
          if (w_any_exp && (w_exp_idx == IW'(i)))
            w_state_nxt[i] = ENT_IDLE;
        end
        default: w_state_nxt[i] = ENT_IDLE;
      endcase
      if (w_cxl_match[i])
        w_state_nxt[i] = ENT_IDLE;
      if (w_state_nxt[i] != ENT_IDLE)
        w_cnt_nxt = w_cnt_nxt + CW'(1);
    end
  end

  // Control state: entry states, arbitration pointer/lock, expiry report and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_state[i] <= ENT_IDLE;
      r_rr_ptr   <= IW'(N-1);
      r_lock_idx <= '0;
      r_lock_vld <= 1'b0;
      r_bubble   <= 1'b0;
      r_exp_vld  <= 1'b0;
      r_exp_uid  <= '0;
      r_count    <= '0;
    end else begin
      for (int i = 0; i < N; i++) r_state[i] <= w_state_nxt[i];
      if (w_issue) r_rr_ptr <= w_pres_idx;
      r_lock_idx <= w_pres_idx;
      r_lock_vld <= w_pres_vld && !out_rdy && !w_pres_cancel;
      r_bubble   <= w_pres_cancel;
      r_exp_vld  <= w_any_exp;
      if (w_any_exp) r_exp_uid <= r_cmd[w_exp_idx].uid;
      r_count    <= w_cnt_nxt;
    end
  end

  // Entry payload needs no reset; it is only observed while the entry is non-idle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      r_cmd[i] <= w_cmd_nxt[i];
      r_ttl[i] <= w_ttl_nxt[i];
    end
  end

  assign in_rdy     = w_any_idle;
  assign out_vld    = w_pres_vld;
  assign out_cmd    = r_cmd[w_pres_idx];
  assign cancel_hit = (|w_cxl_match) || w_alloc_drop;
  assign exp_vld    = r_exp_vld;
  assign exp_uid    = r_exp_uid;
  assign count_r    = r_count;
  assign empty_r    = (r_count == '0);
  assign full_r     = (r_count == CW'(N));

endmodule
